// File: rtl/cache_ctrl_fsm_pkg.sv
// cache_pkg: shared types and default parameters for the cache controller.
//   cache_state_t - controller state encoding
//   DEF_*         - default block geometry and write policy
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB,
    ALLOC,
    WT,
    FLUSH
  } cache_state_t;

  localparam int DEF_BEATS      = 16;
  localparam bit DEF_WRITE_BACK = 1'b1;
  localparam int DEF_SETS       = 16;
  localparam int DEF_WAYS       = 4;

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// cache_ctrl_fsm_if: bundle of the controller's handshake/bus signals.
//   i_* : requester (main FSM), tag compare, AXI master strobes
//   o_* : stall, cache array controls, AXI start strobes, flush status
// master = controller side, slave = environment side.
interface cache_ctrl_fsm_if import cache_pkg::*; #(
  parameter int BEATS = DEF_BEATS,
  parameter int SETS  = DEF_SETS,
  parameter int WAYS  = DEF_WAYS
);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = $clog2(SETS * WAYS);

  logic              i_start_check;
  logic              i_write_req;
  logic              i_hit;
  logic              i_dirty;
  logic              i_r_valid;
  logic              i_r_last;
  logic              i_b_resp;
  logic              i_flush;
  logic              o_stall;
  logic              o_block_write_en;
  logic [BEAT_W-1:0] o_beat_idx;
  logic              o_valid_update;
  logic              o_valid_clear;
  logic              o_lru_update;
  logic              o_dirty_set;
  logic              o_start_read;
  logic              o_start_write;
  logic              o_addr_control;
  logic [LINE_W-1:0] o_line_idx;
  logic              o_flush_done;
  logic              o_refill_err;

  modport master (
    input  i_start_check, i_write_req, i_hit, i_dirty, i_r_valid, i_r_last,
           i_b_resp, i_flush,
    output o_stall, o_block_write_en, o_beat_idx, o_valid_update, o_valid_clear,
           o_lru_update, o_dirty_set, o_start_read, o_start_write, o_addr_control,
           o_line_idx, o_flush_done, o_refill_err
  );

  modport slave (
    output i_start_check, i_write_req, i_hit, i_dirty, i_r_valid, i_r_last,
           i_b_resp, i_flush,
    input  o_stall, o_block_write_en, o_beat_idx, o_valid_update, o_valid_clear,
           o_lru_update, o_dirty_set, o_start_read, o_start_write, o_addr_control,
           o_line_idx, o_flush_done, o_refill_err
  );

endinterface

// File: rtl/cache_beat_counter.sv
// cache_beat_counter: W-bit up-counter that wraps to 0 after MAX.
//   clr  - synchronous clear (wins over en)
//   en   - count one step
//   cnt  - registered count
//   tc   - count is at MAX
//   wrap - this step wraps MAX -> 0
module cache_beat_counter #(
  parameter int W   = 4,
  parameter int MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         wrap
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign tc   = (cnt == MAX_V);
  assign wrap = en && tc;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (wrap)  cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: cache controller between the main FSM and the AXI master.
//   clk, arstn - clock, async active-low reset
//   bus        - cache_ctrl_fsm_if.master (request, tag, AXI strobes in;
//                stall, array controls, AXI starts, flush status out)
// Lookup/refill/write-back/write-through plus a whole-cache flush sweep.
module cache_ctrl_fsm import cache_pkg::*; #(
  parameter int BEATS      = DEF_BEATS,
  parameter bit WRITE_BACK = DEF_WRITE_BACK,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS
) (
  input logic              clk,
  input logic              arstn,
  cache_ctrl_fsm_if.master bus
);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = $clog2(SETS * WAYS);

  cache_state_t      state, state_n, state_prev;
  logic              ret_flush, ret_flush_n;
  logic              fresh;
  logic              beat_clr, beat_en, beat_tc, beat_wrap;
  logic              line_clr, line_en, line_tc, line_wrap;
  logic [BEAT_W-1:0] beat_idx;
  logic [LINE_W-1:0] line_idx;
  logic              refill_err, err_set;

  cache_beat_counter #(.W(BEAT_W), .MAX(BEATS - 1)) u_beat (
    .clk(clk), .arstn(arstn), .clr(beat_clr), .en(beat_en),
    .cnt(beat_idx), .tc(beat_tc), .wrap(beat_wrap)
  );

  cache_beat_counter #(.W(LINE_W), .MAX(SETS * WAYS - 1)) u_line (
    .clk(clk), .arstn(arstn), .clr(line_clr), .en(line_en),
    .cnt(line_idx), .tc(line_tc), .wrap(line_wrap)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      state_prev <= IDLE;
      ret_flush  <= 1'b0;
      refill_err <= 1'b0;
    end else begin
      state      <= state_n;
      state_prev <= state;
      ret_flush  <= ret_flush_n;
      if (err_set) refill_err <= 1'b1;
    end
  end

  // Every state is entered from a different state, so a change marks the
  // entry cycle that fires the one-shot AXI start strobes.
  assign fresh = (state != state_prev);

  always_comb begin
    state_n              = state;
    ret_flush_n          = ret_flush;
    beat_clr             = 1'b0;
    beat_en              = 1'b0;
    line_clr             = 1'b0;
    line_en              = 1'b0;
    err_set              = 1'b0;
    bus.o_stall          = 1'b1;
    bus.o_block_write_en = 1'b0;
    bus.o_valid_update   = 1'b0;
    bus.o_valid_clear    = 1'b0;
    bus.o_lru_update     = 1'b0;
    bus.o_dirty_set      = 1'b0;
    bus.o_start_read     = 1'b0;
    bus.o_start_write    = 1'b0;
    bus.o_addr_control   = 1'b0;
    case (state)
      IDLE: begin
        bus.o_stall = 1'b0;
        if (bus.i_flush) begin
          state_n  = FLUSH;
          line_clr = 1'b1;
        end else if (bus.i_start_check) begin
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.i_hit) begin
          bus.o_stall      = 1'b0;
          bus.o_lru_update = 1'b1;
          state_n          = IDLE;
          if (bus.i_write_req) begin
            if (WRITE_BACK) bus.o_dirty_set = 1'b1;
            else            state_n = WT;
          end
        end else if (bus.i_dirty && WRITE_BACK) begin
          state_n     = WB;
          ret_flush_n = 1'b0;
        end else begin
          state_n  = ALLOC;
          beat_clr = 1'b1;
        end
      end
      WB: begin
        bus.o_addr_control = 1'b1;
        bus.o_start_write  = fresh;
        if (bus.i_b_resp) begin
          if (ret_flush) begin
            // victim written: the swept line is now clean and can be dropped
            bus.o_valid_clear = 1'b1;
            line_en           = 1'b1;
            state_n           = line_tc ? IDLE : FLUSH;
          end else begin
            state_n  = ALLOC;
            beat_clr = 1'b1;
          end
        end
      end
      ALLOC: begin
        bus.o_start_read = fresh;
        if (bus.i_r_valid) begin
          bus.o_block_write_en = 1'b1;
          beat_en              = 1'b1;
          // short block (last too early) or long block (counter wraps)
          err_set = bus.i_r_last ? !beat_tc : beat_wrap;
          if (bus.i_r_last) begin
            bus.o_valid_update = 1'b1;
            beat_clr           = 1'b1;
            state_n            = COMPARE;
          end
        end
      end
      WT: begin
        bus.o_start_write = fresh;
        if (bus.i_b_resp) state_n = IDLE;
      end
      FLUSH: begin
        if (bus.i_dirty && WRITE_BACK) begin
          state_n     = WB;
          ret_flush_n = 1'b1;
        end else begin
          bus.o_valid_clear = 1'b1;
          line_en           = 1'b1;
          if (line_tc) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_beat_idx   = beat_idx;
  assign bus.o_line_idx   = line_idx;
  assign bus.o_refill_err = refill_err;
  assign bus.o_flush_done = line_wrap;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
module tb_cache_ctrl_fsm;
  localparam int BEATS = 4;
  localparam int SETS  = 2;
  localparam int WAYS  = 2;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_ctrl_fsm_if #(.BEATS(BEATS), .SETS(SETS), .WAYS(WAYS)) a ();
  cache_ctrl_fsm_if #(.BEATS(BEATS), .SETS(SETS), .WAYS(WAYS)) b ();

  cache_ctrl_fsm #(.BEATS(BEATS), .WRITE_BACK(1'b1), .SETS(SETS), .WAYS(WAYS)) dut_a (
    .clk(clk), .arstn(arstn), .bus(a.master)
  );
  cache_ctrl_fsm #(.BEATS(BEATS), .WRITE_BACK(1'b0), .SETS(SETS), .WAYS(WAYS)) dut_b (
    .clk(clk), .arstn(arstn), .bus(b.master)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // inputs change 1 time unit after the rising edge, outputs sampled 3 after
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [14:0] outs_a();
    return {a.o_stall, a.o_block_write_en, a.o_beat_idx, a.o_valid_update, a.o_valid_clear,
            a.o_lru_update, a.o_dirty_set, a.o_start_read, a.o_start_write, a.o_addr_control,
            a.o_line_idx, a.o_flush_done, a.o_refill_err};
  endfunction

  function automatic logic [14:0] outs_b();
    return {b.o_stall, b.o_block_write_en, b.o_beat_idx, b.o_valid_update, b.o_valid_clear,
            b.o_lru_update, b.o_dirty_set, b.o_start_read, b.o_start_write, b.o_addr_control,
            b.o_line_idx, b.o_flush_done, b.o_refill_err};
  endfunction

  task automatic idle_inputs();
    a.i_start_check = 0; a.i_write_req = 0; a.i_hit = 0; a.i_dirty = 0;
    a.i_r_valid = 0; a.i_r_last = 0; a.i_b_resp = 0; a.i_flush = 0;
    b.i_start_check = 0; b.i_write_req = 0; b.i_hit = 0; b.i_dirty = 0;
    b.i_r_valid = 0; b.i_r_last = 0; b.i_b_resp = 0; b.i_flush = 0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    idle_inputs();
    #12;
    n_tests++; if (outs_a() !== '0) begin n_fail++; $display("FAIL reset_a: got %h want 0", outs_a()); end
    n_tests++; if (outs_b() !== '0) begin n_fail++; $display("FAIL reset_b: got %h want 0", outs_b()); end
    @(negedge clk) arstn = 1'b1;
  endtask

  task automatic test_load_hit();
    nxt(); a.i_start_check = 1; a.i_hit = 1; settle();
    n_tests++; if (a.o_stall !== 1'b0) begin n_fail++; $display("FAIL hit_idle_stall: got %b want 0", a.o_stall); end
    nxt(); settle();
    n_tests++; if (a.o_lru_update !== 1'b1) begin n_fail++; $display("FAIL hit_lru: got %b want 1", a.o_lru_update); end
    n_tests++; if (a.o_stall !== 1'b0) begin n_fail++; $display("FAIL hit_stall: got %b want 0", a.o_stall); end
    n_tests++; if (a.o_start_read !== 1'b0) begin n_fail++; $display("FAIL hit_no_read: got %b want 0", a.o_start_read); end
    nxt(); a.i_start_check = 0; a.i_hit = 0; settle();
    n_tests++; if (a.o_stall !== 1'b0) begin n_fail++; $display("FAIL hit_back_idle: got %b want 0", a.o_stall); end
  endtask

  // One request on the write-back instance. The bench plays the tag array
  // and AXI slave: write response d cycles after start_write, beat i after
  // start_read with a gap g[2i+:2]. Expectations come from the timing rules.
  task automatic run_txn(input bit hit, input bit store, input bit dirty, input int d,
                         input logic [7:0] g, input string tag);
    int  t_done, n_rd, n_wr, n_bwe, n_vu, n_ds, bad_idx, bad_ac, b_at, acc, gsum, exp_lat;
    int  beat_at[4];
    bit  refilled;
    t_done = -1; n_rd = 0; n_wr = 0; n_bwe = 0; n_vu = 0; n_ds = 0;
    bad_idx = 0; bad_ac = 0; b_at = -1; refilled = 0;
    for (int i = 0; i < 4; i++) beat_at[i] = -1;
    nxt();
    a.i_start_check = 1; a.i_write_req = store; a.i_hit = hit; a.i_dirty = dirty;
    settle();
    for (int c = 1; c <= 200 && t_done < 0; c++) begin
      nxt();
      a.i_b_resp = (c == b_at);
      a.i_r_valid = 0; a.i_r_last = 0;
      for (int i = 0; i < 4; i++)
        if (c == beat_at[i]) begin a.i_r_valid = 1; a.i_r_last = (i == 3); end
      a.i_hit = hit | refilled;
      settle();
      if (a.o_start_read) begin
        n_rd++; acc = c;
        for (int i = 0; i < 4; i++) begin acc += 1 + int'(g[2*i +: 2]); beat_at[i] = acc; end
      end
      if (a.o_start_write) begin n_wr++; b_at = c + d; if (a.o_addr_control !== 1'b1) bad_ac++; end
      if (a.o_block_write_en) begin if (a.o_beat_idx !== n_bwe[1:0]) bad_idx++; n_bwe++; end
      if (a.o_valid_update) n_vu++;
      if (a.o_dirty_set) n_ds++;
      if (a.i_r_valid && a.i_r_last) refilled = 1;
      if (a.o_lru_update && !a.o_stall) t_done = c;
    end
    gsum = int'(g[1:0]) + int'(g[3:2]) + int'(g[5:4]) + int'(g[7:6]);
    if (hit) exp_lat = 1;
    else     exp_lat = 2 + (dirty ? d + 1 : 0) + 5 + gsum;
    n_tests++; if (t_done != exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", tag, t_done, exp_lat); end
    n_tests++; if (n_rd != (hit ? 0 : 1)) begin n_fail++; $display("FAIL %s_start_read: got %0d want %0d", tag, n_rd, hit ? 0 : 1); end
    n_tests++; if (n_wr != ((!hit && dirty) ? 1 : 0)) begin n_fail++; $display("FAIL %s_start_write: got %0d want %0d", tag, n_wr, (!hit && dirty) ? 1 : 0); end
    n_tests++; if (bad_ac != 0) begin n_fail++; $display("FAIL %s_addr_control: got %0d bad want 0", tag, bad_ac); end
    n_tests++; if (n_bwe != (hit ? 0 : BEATS)) begin n_fail++; $display("FAIL %s_beats: got %0d want %0d", tag, n_bwe, hit ? 0 : BEATS); end
    n_tests++; if (bad_idx != 0) begin n_fail++; $display("FAIL %s_beat_idx: got %0d bad want 0", tag, bad_idx); end
    n_tests++; if (n_vu != (hit ? 0 : 1)) begin n_fail++; $display("FAIL %s_valid_update: got %0d want %0d", tag, n_vu, hit ? 0 : 1); end
    n_tests++; if (n_ds != int'(store)) begin n_fail++; $display("FAIL %s_dirty_set: got %0d want %0d", tag, n_ds, store); end
    nxt();
    a.i_start_check = 0; a.i_write_req = 0; a.i_hit = 0; a.i_dirty = 0;
    a.i_r_valid = 0; a.i_r_last = 0; a.i_b_resp = 0;
    settle();
    n_tests++; if (a.o_refill_err !== 1'b0) begin n_fail++; $display("FAIL %s_refill_err: got %b want 0", tag, a.o_refill_err); end
    n_tests++; if (a.o_stall !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got stall %b want 0", tag, a.o_stall); end
  endtask

  task automatic test_random_txns();
    run_txn(0, 0, 0, 1, 8'h00, "clean_miss");
    run_txn(0, 0, 1, 5, 8'h00, "dirty_miss");
    for (int k = 0; k < 16; k++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 6)), 8'($urandom), "rand");
  endtask

  task automatic test_write_through();
    int n_clr, n_sw, fd_c;
    nxt(); b.i_start_check = 1; b.i_write_req = 1; b.i_hit = 1; settle();
    nxt(); settle();
    n_tests++; if (b.o_lru_update !== 1'b1 || b.o_stall !== 1'b0) begin n_fail++; $display("FAIL wt_hit: got lru %b stall %b want 1 0", b.o_lru_update, b.o_stall); end
    n_tests++; if (b.o_dirty_set !== 1'b0) begin n_fail++; $display("FAIL wt_dirty_set: got %b want 0", b.o_dirty_set); end
    nxt(); b.i_start_check = 0; b.i_write_req = 0; b.i_hit = 0; settle();
    n_tests++; if (b.o_start_write !== 1'b1 || b.o_addr_control !== 1'b0) begin n_fail++; $display("FAIL wt_start: got sw %b ac %b want 1 0", b.o_start_write, b.o_addr_control); end
    n_tests++; if (b.o_stall !== 1'b1 || b.o_dirty_set !== 1'b0) begin n_fail++; $display("FAIL wt_stall: got stall %b ds %b want 1 0", b.o_stall, b.o_dirty_set); end
    nxt(); settle();
    nxt(); b.i_b_resp = 1; settle();
    n_tests++; if (b.o_stall !== 1'b1 || b.o_start_write !== 1'b0) begin n_fail++; $display("FAIL wt_wait: got stall %b sw %b want 1 0", b.o_stall, b.o_start_write); end
    nxt(); b.i_b_resp = 0; settle();
    n_tests++; if (b.o_stall !== 1'b0) begin n_fail++; $display("FAIL wt_idle: got stall %b want 0", b.o_stall); end
    // dirty miss without write-back goes straight to refill
    nxt(); b.i_start_check = 1; b.i_dirty = 1; settle();
    nxt(); settle();
    nxt(); settle();
    n_tests++; if (b.o_start_read !== 1'b1 || b.o_start_write !== 1'b0) begin n_fail++; $display("FAIL wt_miss: got sr %b sw %b want 1 0", b.o_start_read, b.o_start_write); end
    for (int i = 0; i < 4; i++) begin nxt(); b.i_r_valid = 1; b.i_r_last = (i == 3); settle(); end
    nxt(); b.i_r_valid = 0; b.i_r_last = 0; b.i_hit = 1; settle();
    n_tests++; if (b.o_lru_update !== 1'b1 || b.o_stall !== 1'b0) begin n_fail++; $display("FAIL wt_refill_hit: got lru %b stall %b want 1 0", b.o_lru_update, b.o_stall); end
    nxt(); b.i_start_check = 0; b.i_hit = 0; b.i_flush = 1; settle();
    // flush with every line dirty: no writes without write-back
    n_clr = 0; n_sw = 0; fd_c = -1;
    for (int c = 1; c <= 6; c++) begin
      nxt(); b.i_flush = 0; settle();
      if (b.o_valid_clear) n_clr++;
      if (b.o_start_write) n_sw++;
      if (b.o_flush_done) fd_c = c;
    end
    b.i_dirty = 0;
    n_tests++; if (n_clr != SETS * WAYS || n_sw != 0) begin n_fail++; $display("FAIL wt_flush: got clr %0d wr %0d want %0d 0", n_clr, n_sw, SETS * WAYS); end
    n_tests++; if (fd_c != SETS * WAYS) begin n_fail++; $display("FAIL wt_flush_done: got cycle %0d want %0d", fd_c, SETS * WAYS); end
  endtask

  // Flush sweep on the write-back instance with dirty lines given by mask.
  task automatic run_flush(input logic [3:0] mask, input int d, input string tag);
    int n_clr, n_wr, n_fd, bad, b_at, exp_next, exp_wr, done_c;
    n_clr = 0; n_wr = 0; n_fd = 0; bad = 0; b_at = -1; exp_next = 0; done_c = -1;
    exp_wr = $countones(mask);
    nxt(); a.i_flush = 1; a.i_start_check = 1; a.i_hit = 1; settle();
    for (int c = 1; c <= 100 && done_c < 0; c++) begin
      nxt();
      a.i_flush = 0; a.i_start_check = 0; a.i_hit = 0;
      a.i_dirty = mask[a.o_line_idx];
      a.i_b_resp = (c == b_at);
      settle();
      if (a.o_valid_clear) begin if (int'(a.o_line_idx) != exp_next) bad++; exp_next++; n_clr++; end
      if (a.o_start_write) begin n_wr++; b_at = c + d; if (!mask[a.o_line_idx] || !a.o_addr_control) bad++; end
      if (a.o_flush_done) begin n_fd++; done_c = c; if (!a.o_valid_clear || int'(a.o_line_idx) != SETS * WAYS - 1) bad++; end
      if (a.o_lru_update) bad++;
    end
    nxt(); a.i_dirty = 0; a.i_b_resp = 0; settle();
    n_tests++; if (n_clr != SETS * WAYS) begin n_fail++; $display("FAIL %s_clears: got %0d want %0d", tag, n_clr, SETS * WAYS); end
    n_tests++; if (n_wr != exp_wr) begin n_fail++; $display("FAIL %s_writes: got %0d want %0d", tag, n_wr, exp_wr); end
    n_tests++; if (n_fd != 1) begin n_fail++; $display("FAIL %s_done: got %0d want 1", tag, n_fd); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL %s_order: got %0d bad events want 0", tag, bad); end
    n_tests++; if (a.o_line_idx !== '0 || a.o_stall !== 1'b0) begin n_fail++; $display("FAIL %s_end: got idx %0d stall %b want 0 0", tag, a.o_line_idx, a.o_stall); end
  endtask

  task automatic test_flush();
    run_flush(4'b0100, 2, "flush_dir");
    run_flush(4'b1000, 1, "flush_last");
    for (int k = 0; k < 3; k++) run_flush(4'($urandom), int'($urandom_range(1, 4)), "flush_rand");
  endtask

  task automatic test_short_refill_reset();
    nxt(); a.i_start_check = 1; settle();
    nxt(); settle();
    nxt(); settle();
    n_tests++; if (a.o_start_read !== 1'b1) begin n_fail++; $display("FAIL short_start_read: got %b want 1", a.o_start_read); end
    for (int i = 0; i < 3; i++) begin
      nxt(); a.i_r_valid = 1; a.i_r_last = (i == 2); settle();
      n_tests++; if (a.o_block_write_en !== 1'b1 || int'(a.o_beat_idx) != i) begin n_fail++; $display("FAIL short_beat: got en %b idx %0d want 1 %0d", a.o_block_write_en, a.o_beat_idx, i); end
    end
    n_tests++; if (a.o_refill_err !== 1'b0 || a.o_valid_update !== 1'b1) begin n_fail++; $display("FAIL short_last: got err %b vu %b want 0 1", a.o_refill_err, a.o_valid_update); end
    nxt(); a.i_r_valid = 0; a.i_r_last = 0; a.i_hit = 1; settle();
    n_tests++; if (a.o_refill_err !== 1'b1 || a.o_lru_update !== 1'b1) begin n_fail++; $display("FAIL short_err: got err %b lru %b want 1 1", a.o_refill_err, a.o_lru_update); end
    nxt(); a.i_start_check = 0; a.i_hit = 0; settle();
    n_tests++; if (a.o_refill_err !== 1'b1) begin n_fail++; $display("FAIL short_sticky: got %b want 1", a.o_refill_err); end
    // new miss, reset while the refill is in progress
    nxt(); a.i_start_check = 1; settle();
    nxt(); settle();
    nxt(); settle();
    nxt(); a.i_r_valid = 1; settle();
    nxt(); a.i_r_valid = 0; settle();
    n_tests++; if (a.o_stall !== 1'b1 || a.o_beat_idx !== 2'd1) begin n_fail++; $display("FAIL midalloc: got stall %b idx %0d want 1 1", a.o_stall, a.o_beat_idx); end
    arstn = 1'b0;
    idle_inputs();
    #1;
    n_tests++; if (outs_a() !== '0) begin n_fail++; $display("FAIL midalloc_reset: got %h want 0", outs_a()); end
    @(negedge clk) arstn = 1'b1;
    run_txn(1, 0, 0, 1, 8'h00, "post_reset");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_hit();
    test_random_txns();
    test_write_through();
    test_flush();
    test_short_refill_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
